// File: rtl/fifo_pkg.sv
// Shared helpers for both sides of the dual-clock FIFO: sizing and
// Gray/binary conversion for the pointers that cross clock domains.
package fifo_pkg;

    localparam int FIFO_DEPTH = 64;

    // Ceiling log2; clog2(DATA_DEPTH-1) gives the RAM address width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Operands are zero-extended to 32 bits, so one pair serves any PTR_WIDTH.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus entering a new clock domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= '0;
            o_q  <= '0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: owns the read pointer, drives the
// RAM read port and derives empty / almost-empty / level from the synced wptr.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter  int DATA_DEPTH      = FIFO_DEPTH,
    parameter  int ALMOST_EMPTY_TH = 4,
    localparam int ADDR_WIDTH      = clog2(DATA_DEPTH - 1),
    localparam int PTR_WIDTH       = ADDR_WIDTH + 1
) (
    input  logic                  i_rdclk,
    input  logic                  i_rdrst_n,
    input  logic                  i_rd_req,
    input  logic [PTR_WIDTH-1:0]  i_wptr_gray,
    output logic                  o_rden,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic                  o_rvalid,
    output logic [PTR_WIDTH-1:0]  o_rptr_gray,
    output logic                  o_empty,
    output logic                  o_almost_empty,
    output logic [PTR_WIDTH-1:0]  o_rd_level,
    output logic                  o_underflow
);

    localparam logic [PTR_WIDTH-1:0] AE_TH = PTR_WIDTH'(ALMOST_EMPTY_TH);

    logic [PTR_WIDTH-1:0] wgray_s;
    logic [PTR_WIDTH-1:0] wbin_s;
    logic [PTR_WIDTH-1:0] rbin;
    logic [PTR_WIDTH-1:0] rbin_next;
    logic [PTR_WIDTH-1:0] rgray_next;
    logic [PTR_WIDTH-1:0] level_next;
    logic                 acc;

    sync_2ff #(
        .WIDTH (PTR_WIDTH)
    ) u_wptr_sync (
        .i_clk   (i_rdclk),
        .i_rst_n (i_rdrst_n),
        .i_d     (i_wptr_gray),
        .o_q     (wgray_s)
    );

    // Level is computed against the post-read pointer so the flags already
    // account for the word being consumed this cycle.
    always_comb begin
        wbin_s     = PTR_WIDTH'(gray2bin(32'(wgray_s)));
        acc        = i_rd_req & ~o_empty;
        rbin_next  = rbin + {{(PTR_WIDTH-1){1'b0}}, acc};
        rgray_next = PTR_WIDTH'(bin2gray(32'(rbin_next)));
        level_next = wbin_s - rbin_next;
    end

    assign o_rden  = acc;
    assign o_raddr = rbin[ADDR_WIDTH-1:0];

    always_ff @(posedge i_rdclk or negedge i_rdrst_n) begin
        if (!i_rdrst_n) begin
            rbin           <= '0;
            o_rptr_gray    <= '0;
            o_rvalid       <= 1'b0;
            o_empty        <= 1'b1;
            o_almost_empty <= 1'b1;
            o_rd_level     <= '0;
            o_underflow    <= 1'b0;
        end else begin
            rbin           <= rbin_next;
            o_rptr_gray    <= rgray_next;
            o_rvalid       <= acc;
            // Pessimistic: a write still in the synchroniser keeps us empty.
            o_empty        <= (rgray_next == wgray_s);
            o_almost_empty <= (level_next <= AE_TH);
            o_rd_level     <= level_next;
            o_underflow    <= i_rd_req & o_empty;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomised and directed bench for fifo_rd_ctrl against an integer
// read/write-count model of the FIFO.
module tb_fifo_rd_ctrl;

    localparam int DEPTH = 64;
    localparam int TH    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rd_req;
    logic [6:0] wptr_gray;
    logic       rden;
    logic [5:0] raddr;
    logic       rvalid;
    logic [6:0] rptr_gray;
    logic       empty;
    logic       aempty;
    logic [6:0] level;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    // model state: counts of words ever written / read, plus sync delay line
    int m_wr, m_rd, m_s1, m_s2, m_level;
    bit m_empty, m_ae, m_rvalid, m_uf;

    fifo_rd_ctrl #(
        .DATA_DEPTH      (DEPTH),
        .ALMOST_EMPTY_TH (TH)
    ) dut (
        .i_rdclk        (clk),
        .i_rdrst_n      (rst_n),
        .i_rd_req       (rd_req),
        .i_wptr_gray    (wptr_gray),
        .o_rden         (rden),
        .o_raddr        (raddr),
        .o_rvalid       (rvalid),
        .o_rptr_gray    (rptr_gray),
        .o_empty        (empty),
        .o_almost_empty (aempty),
        .o_rd_level     (level),
        .o_underflow    (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] gray(input int x);
        logic [6:0] b;
        b = 7'(x % 128);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [12:0] m_flags();
        return {m_empty, m_ae, 7'(m_level), m_rvalid, m_uf, 1'b0, 1'b0};
    endfunction

    function automatic logic [12:0] d_flags();
        return {empty, aempty, level, rvalid, underflow, 1'b0, 1'b0};
    endfunction

    // Advance the model by one read-clock edge using the current inputs.
    task automatic tick();
        bit acc;
        acc      = rd_req && !m_empty;
        m_uf     = rd_req && m_empty;
        m_rvalid = acc;
        if (acc) m_rd++;
        m_level  = m_s2 - m_rd;
        m_empty  = (m_level == 0);
        m_ae     = (m_level <= TH);
        m_s2     = m_s1;
        m_s1     = m_wr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rd_req    = 1'b0;
        wptr_gray = '0;
        m_wr = 0; m_rd = 0; m_s1 = 0; m_s2 = 0; m_level = 0;
        m_empty = 1; m_ae = 1; m_rvalid = 0; m_uf = 0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({empty, aempty, level, raddr, rptr_gray, rvalid, underflow, rden} !==
                {1'b1, 1'b1, 7'd0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: e=%b ae=%b lvl=%0d ra=%0d rg=%h rv=%b uf=%b rden=%b", i,
                         empty, aempty, level, raddr, rptr_gray, rvalid, underflow, rden);
            end
        end
    endtask

    task automatic test_single_word();
        m_wr = 1;
        wptr_gray = gray(m_wr);
        tick(); tick();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL wr_latency_early: empty=%b want 1 after 2 edges", empty);
        end
        tick();
        checks++;
        if ({empty, level} !== {1'b0, 7'd1}) begin
            errors++;
            $display("FAIL wr_latency_3rd: empty=%b lvl=%0d want 0/1", empty, level);
        end
        rd_req = 1'b1;
        #1;
        checks++;
        if ({rden, raddr} !== {1'b1, 6'd0}) begin
            errors++;
            $display("FAIL first_read: rden=%b raddr=%0d want 1/0", rden, raddr);
        end
        tick();
        rd_req = 1'b0;
        checks++;
        if ({rvalid, empty, rptr_gray, level} !== {1'b1, 1'b1, 7'd1, 7'd0}) begin
            errors++;
            $display("FAIL after_read: rv=%b e=%b rg=%h lvl=%0d want 1/1/01/0",
                     rvalid, empty, rptr_gray, level);
        end
    endtask

    task automatic test_underflow();
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rden !== 1'b0) begin
                errors++;
                $display("FAIL uf_rden cyc%0d: rden=%b want 0", i, rden);
            end
            tick();
            checks++;
            if ({underflow, raddr, rptr_gray} !== {m_uf, 6'(m_rd % DEPTH), gray(m_rd)}) begin
                errors++;
                $display("FAIL uf_state cyc%0d: uf=%b ra=%0d rg=%h want %b/%0d/%h", i,
                         underflow, raddr, rptr_gray, m_uf, m_rd % DEPTH, gray(m_rd));
            end
        end
        rd_req = 1'b0;
        tick();
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL uf_clear: uf=%b want 0", underflow);
        end
    endtask

    task automatic test_full_drain();
        do_reset();
        m_wr = 64;
        wptr_gray = 7'b1100000;
        tick(); tick(); tick();
        checks++;
        if ({level, aempty, empty} !== {7'd64, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL full_level: lvl=%0d ae=%b e=%b want 64/0/0", level, aempty, empty);
        end
        rd_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            checks++;
            if ({rden, raddr} !== {1'b1, 6'(i)}) begin
                errors++;
                $display("FAIL drain_addr %0d: rden=%b raddr=%0d", i, rden, raddr);
            end
            tick();
        end
        rd_req = 1'b0;
        checks++;
        if ({level, aempty, empty} !== {7'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL drain_level: lvl=%0d ae=%b e=%b want 4/1/0", level, aempty, empty);
        end
    endtask

    task automatic test_stream_wrap();
        int wraps;
        int gwraps;
        logic [5:0] pa;
        logic [6:0] pg;
        wraps  = 0;
        gwraps = 0;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            if (($urandom_range(0, 3) != 0) && (m_wr - m_rd < DEPTH)) m_wr++;
            wptr_gray = gray(m_wr);
            rd_req    = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if ({rden, raddr} !== {rd_req && !m_empty, 6'(m_rd % DEPTH)}) begin
                errors++;
                $display("FAIL stream_port %0d: rden=%b ra=%0d want %b/%0d", i, rden, raddr,
                         rd_req && !m_empty, m_rd % DEPTH);
            end
            pa = raddr;
            pg = rptr_gray;
            tick();
            if (pa == 6'd63 && raddr == 6'd0) wraps++;
            if (pg == 7'b1000000 && rptr_gray == 7'd0) gwraps++;
            checks++;
            if ({d_flags(), rptr_gray} !== {m_flags(), gray(m_rd)}) begin
                errors++;
                $display("FAIL stream_flags %0d: e/ae/lvl/rv/uf=%b/%b/%0d/%b/%b rg=%h want %b/%b/%0d/%b/%b rg=%h",
                         i, empty, aempty, level, rvalid, underflow, rptr_gray,
                         m_empty, m_ae, m_level, m_rvalid, m_uf, gray(m_rd));
            end
        end
        rd_req = 1'b0;
        checks++;
        if (wraps < 2 || gwraps < 1) begin
            errors++;
            $display("FAIL stream_wrap: addr wraps=%0d gray wraps=%0d want >=2/>=1", wraps, gwraps);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        m_wr = 10;
        wptr_gray = gray(10);
        tick(); tick(); tick();
        rd_req = 1'b1;
        tick();
        tick();
        checks++;
        if ({level, raddr} !== {7'd8, 6'd2}) begin
            errors++;
            $display("FAIL pre_reset: lvl=%0d ra=%0d want 8/2", level, raddr);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({empty, aempty, level, raddr, rptr_gray, rvalid, underflow, rden} !==
            {1'b1, 1'b1, 7'd0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: e=%b ae=%b lvl=%0d ra=%0d rg=%h rv=%b uf=%b rden=%b",
                     empty, aempty, level, raddr, rptr_gray, rvalid, underflow, rden);
        end
        do_reset();
    endtask

    initial begin
        rst_n     = 1'b0;
        rd_req    = 1'b0;
        wptr_gray = '0;
        #12;
        test_reset();
        test_single_word();
        test_underflow();
        test_full_drain();
        test_stream_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
